// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_unit
//  Purpose  : Instruction fetcher. Generates sequential PCs, issues one
//             valid/ready request at a time to the instruction cache and
//             buffers returned instructions (with their PC) in an in-order
//             queue for decode. Branch/jump redirects flush the queue and
//             discard any in-flight response.
//  Ports    : clk, reset (sync, active-low)
//             fetch_enable                 - keep fetching when 1
//             redirect_valid/target        - 1-cycle redirect pulse + new PC
//             mem_req_valid/ready/addr     - request channel to the cache
//             mem_resp_valid/data          - in-order response from the cache
//             out_valid/ready/instr/addr   - queue head towards decode
//             busy                         - FSM active or queue non-empty
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int unsigned        ADDR_W      = 64,
    parameter int unsigned        INSTR_W     = 32,
    parameter int unsigned        QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter int unsigned        PC_STEP     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_enable,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_target,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_resp_valid,
    input  logic [INSTR_W-1:0]  mem_resp_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                busy
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;   // PC of the outstanding request
    logic               discard_q, discard_d;     // drop the next response

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] instr_mem_q [QUEUE_DEPTH];
    logic [ADDR_W-1:0]  addr_mem_q  [QUEUE_DEPTH];

    logic               w_push;
    logic               w_pop;
    logic               w_credit;

    // ------------------------------------------------------------------
    // Queue control. A redirect flushes the queue, so any push or pop in
    // that same cycle is suppressed.
    // ------------------------------------------------------------------
    assign w_push = (state_q == S_WAIT) && mem_resp_valid && !discard_q && !redirect_valid;
    assign w_pop  = (count_q != '0) && out_ready && !redirect_valid;

    always_comb begin
        count_d = count_q;
        if (redirect_valid) begin
            count_d = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // A new request is only started if the queue, as it will look next
    // cycle, still has room for its response. With at most one request in
    // flight this guarantees a response never meets a full queue.
    assign w_credit = (count_d < DEPTH_CNT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible while count_q says so.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            instr_mem_q[wr_ptr_q] <= mem_resp_data;
            addr_mem_q[wr_ptr_q]  <= req_addr_q;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_enable && w_credit) state_d = S_REQ;
            end
            S_REQ: begin
                // Held until accepted, regardless of fetch_enable. A redirect
                // without ready simply retargets the request via pc_d below.
                if (mem_req_ready) begin
                    state_d    = S_WAIT;
                    req_addr_d = pc_q;
                    pc_d       = pc_q + STEP;
                    if (redirect_valid) discard_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    // A response coinciding with a redirect is dropped by
                    // w_push; no discard needs to be armed for it.
                    discard_d = 1'b0;
                    state_d   = (fetch_enable && w_credit) ? S_REQ : S_IDLE;
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect_valid) pc_d = redirect_target;
    end

    // ------------------------------------------------------------------
    // FSM / queue: output logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_valid = (state_q == S_REQ);
        mem_req_addr  = pc_q;
        out_valid     = (count_q != '0);
        out_instr     = '0;
        out_addr      = '0;
        if (out_valid) begin
            out_instr = instr_mem_q[rd_ptr_q];
            out_addr  = addr_mem_q[rd_ptr_q];
        end
        busy = (state_q != S_IDLE) || out_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue_unit
//  Purpose  : Self-checking bench for fetch_queue_unit. A driver process acts
//             as cache and decode, and keeps an abstract model (PC value,
//             one outstanding request record, queue of expected entries).
//             A monitor process compares the queue head and request
//             stability every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DEPTH   = 4;
    localparam logic [ADDR_W-1:0] RST_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } entry_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                fetch_enable;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_target;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_resp_valid;
    logic [INSTR_W-1:0]  mem_resp_data;
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_instr;
    logic [ADDR_W-1:0]   out_addr;
    logic                busy;

    fetch_queue_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .QUEUE_DEPTH(DEPTH),
        .RESET_PC(RST_PC), .PC_STEP(4)
    ) dut (
        .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Knobs written only by the main sequence
    logic              k_rst = 1'b1;
    logic              k_en = 1'b0;
    int                k_rdy = 1;        // 0/1 forced, 2 random
    int                k_ordy = 1;       // 0/1 forced, 2 random
    logic              k_redir_rand = 1'b0;
    int                k_redir_req = 0;  // bump to request one redirect
    logic [ADDR_W-1:0] k_redir_tgt = '0;
    int                k_dmin = 0, k_dmax = 0;

    // Model state written only by the driver
    entry_t            exp_q[$];
    int                flush_ptr = 0;    // entries below this index are flushed
    logic [ADDR_W-1:0] m_pc = RST_PC;
    logic              o_pend = 1'b0, o_drop = 1'b0;
    logic [ADDR_W-1:0] o_addr = '0;
    int                c_delay = 0;
    int                n_hs = 0;
    logic [ADDR_W-1:0] m_last_hs = '0;
    int                redir_ack = 0;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [ADDR_W-1:0] act,
                       input logic [ADDR_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: cache + decode stimulus, and reference model update
    // ------------------------------------------------------------------
    initial begin : driver
        logic s_hs, s_resp, s_redir, s_rst;
        logic [ADDR_W-1:0]  s_addr, s_tgt;
        logic [INSTR_W-1:0] s_data;
        reset = 1'b0; fetch_enable = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_data = '0; out_ready = 1'b0;
        forever begin
            @(negedge clk);
            reset        = !k_rst;
            fetch_enable = k_en;
            mem_req_ready = (k_rdy == 2) ? 1'($urandom_range(0, 1)) : (k_rdy == 1);
            out_ready     = (k_ordy == 2) ? 1'($urandom_range(0, 1)) : (k_ordy == 1);
            redirect_valid = 1'b0;
            if (redir_ack != k_redir_req) begin
                redir_ack       = k_redir_req;
                redirect_valid  = 1'b1;
                redirect_target = k_redir_tgt;
            end else if (k_redir_rand && $urandom_range(0, 9) == 0) begin
                redirect_valid  = 1'b1;
                redirect_target = ($urandom_range(0, 7) == 0) ? {{(ADDR_W-4){1'b1}}, 4'hC}
                                : {32'($urandom), 32'($urandom)} & ~64'h3;
            end
            mem_resp_valid = o_pend && (c_delay == 0);
            mem_resp_data  = 32'($urandom);
            #1;
            s_rst   = !reset;
            s_hs    = mem_req_valid && mem_req_ready;
            s_addr  = mem_req_addr;
            s_resp  = mem_resp_valid;
            s_data  = mem_resp_data;
            s_redir = redirect_valid;
            s_tgt   = redirect_target;
            if (s_hs && !s_rst) chk("req_addr", s_addr, m_pc);
            @(posedge clk);
            #1;
            if (s_rst) begin
                flush_ptr = exp_q.size();
                o_pend = 1'b0; o_drop = 1'b0; m_pc = RST_PC;
            end else begin
                if (s_resp) begin
                    if (!o_drop && !s_redir) exp_q.push_back('{addr: o_addr, data: s_data});
                    o_pend = 1'b0;
                end else if (o_pend) begin
                    if (s_redir) o_drop = 1'b1;
                    if (c_delay > 0) c_delay--;
                end
                if (s_redir) flush_ptr = exp_q.size();
                if (s_hs) begin
                    o_pend = 1'b1; o_addr = s_addr; o_drop = s_redir;
                    c_delay = $urandom_range(k_dmin, k_dmax);
                    n_hs++; m_last_hs = s_addr;
                end
                if (s_redir)   m_pc = s_tgt;
                else if (s_hs) m_pc = m_pc + 64'd4;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: queue head against the model, request hold while stalled
    // ------------------------------------------------------------------
    initial begin : monitor
        int m_rd = 0;
        int head;
        logic p_stall = 1'b0;
        logic [ADDR_W-1:0] p_addr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                head = (m_rd > flush_ptr) ? m_rd : flush_ptr;
                chk("out_valid", 64'(out_valid), 64'(exp_q.size() > head));
                if (out_valid && exp_q.size() > head) begin
                    chk("out_addr", out_addr, exp_q[head].addr);
                    chk("out_instr", 64'(out_instr), 64'(exp_q[head].data));
                    if (out_ready && !redirect_valid) m_rd = head + 1;
                end
                if (p_stall) begin
                    chk("req_hold_valid", 64'(mem_req_valid), 64'd1);
                    chk("req_hold_addr", mem_req_addr, p_addr);
                end
                p_stall = mem_req_valid && !mem_req_ready && !redirect_valid;
                p_addr  = mem_req_addr;
            end else begin
                p_stall = 1'b0;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #3;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, "_req_addr"}, mem_req_addr, RST_PC);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
        chk({tag, "_out_addr"}, out_addr, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_in_wait(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            wait_cycles(1);
            if (o_pend && !mem_resp_valid) found = 1'b1;
        end
        chk(tag, 64'(found), 64'd1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        int k, h0;
        logic [ADDR_W-1:0] a0;
        logic hit;

        wait_cycles(3);
        k_rst = 1'b0;
        wait_cycles(1);
        check_reset_outputs("reset");

        // Streaming: first output three cycles after enable
        k_en = 1'b1;
        wait_cycles(1);
        k = 0;
        while (!out_valid && k < 10) begin
            wait_cycles(1);
            k++;
        end
        chk("first_out_latency", 64'(k), 64'd3);
        wait_cycles(20);

        // Credit: decode stalled, exactly DEPTH requests
        k_en = 1'b0;
        wait_cycles(20);
        k_ordy = 0; h0 = n_hs; k_en = 1'b1;
        wait_cycles(30);
        chk("credit_fill", 64'(n_hs - h0), 64'(DEPTH));
        chk("credit_req_stopped", 64'(mem_req_valid), 64'd0);
        h0 = n_hs; k_ordy = 1;
        wait_cycles(1);
        k_ordy = 0;
        wait_cycles(20);
        chk("credit_one_pop", 64'(n_hs - h0), 64'd1);

        // Redirect while waiting, response two cycles later
        k_ordy = 1; k_en = 1'b0;
        wait_cycles(20);
        k_dmin = 2; k_dmax = 2; k_en = 1'b1;
        wait_in_wait("redir_reach_wait");
        k_redir_tgt = 64'h1000; k_redir_req++;
        wait_cycles(2);
        chk("redir_queue_empty", 64'(out_valid), 64'd0);
        h0 = n_hs; hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            wait_cycles(1);
            if (n_hs != h0) hit = 1'b1;
        end
        chk("redir_next_addr", m_last_hs, 64'h1000);
        k_dmin = 0; k_dmax = 0;

        // Stall: ready low for 5 cycles
        k_en = 1'b0;
        wait_cycles(20);
        k_rdy = 0; k_en = 1'b1;
        wait_cycles(2);
        a0 = mem_req_addr; h0 = n_hs;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(mem_req_valid), 64'd1);
            chk("stall_addr", mem_req_addr, a0);
            wait_cycles(1);
        end
        k_rdy = 1; k_en = 1'b0;
        wait_cycles(10);
        chk("stall_one_accept", 64'(n_hs - h0), 64'd1);
        k_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            wait_cycles(1);
            if (mem_req_valid) hit = 1'b1;
        end
        chk("stall_pc_once", mem_req_addr, a0 + 64'd4);

        // PC wrap
        k_en = 1'b0;
        wait_cycles(20);
        k_redir_tgt = {{(ADDR_W-4){1'b1}}, 4'hC}; k_redir_req++;
        wait_cycles(1);
        h0 = n_hs; k_en = 1'b1;
        for (int i = 0; i < 20 && n_hs != h0 + 2; i++) wait_cycles(1);
        chk("wrap_addr", m_last_hs, 64'd0);

        // Reset while waiting for a response
        k_dmin = 1; k_dmax = 3;
        wait_in_wait("rst_reach_wait");
        k_rst = 1'b1;
        wait_cycles(1);
        k_rst = 1'b0;
        wait_cycles(1);
        check_reset_outputs("rst_wait");

        // Randomised traffic
        k_rdy = 2; k_ordy = 2; k_redir_rand = 1'b1; k_dmin = 0; k_dmax = 2;
        h0 = n_hs;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) k_en = !k_en;
            if ($urandom_range(0, 199) == 0) k_en = 1'b1;
            wait_cycles(1);
        end
        chk("random_progress", 64'(n_hs - h0 > 100), 64'd1);

        k_redir_rand = 1'b0; k_ordy = 1; k_rdy = 1; k_en = 1'b0;
        wait_cycles(20);
        chk("drained_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
